// File: rtl/mp_arith_pkg.sv
// -----------------------------------------------------------------------------
// mp_arith_pkg
// Shared definitions for the multi-precision arithmetic datapath:
//   op_e    - operation encoding driven on mp_addsub.op
//   state_e - sequencer states of mp_addsub
//   nlimb() - number of LIMB-bit slices needed to cover a WIDTH-bit operand,
//             also used by the Montgomery controller to size its loops
// -----------------------------------------------------------------------------
package mp_arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SUB    = 2'b01,
    OP_MODSUB = 2'b10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SEL,
    ST_DONE
  } state_e;

  function automatic int nlimb(input int width, input int limb);
    return (width + limb - 1) / limb;
  endfunction

endpackage

// File: rtl/mp_limb_adder.sv
// -----------------------------------------------------------------------------
// mp_limb_adder
// Combinational LIMB-bit adder slice with carry chaining. With invert_b set
// the B operand is complemented, so subtraction is A + ~B + carry_in.
// Ports:
//   a, b      LIMB-bit operands
//   invert_b  complement b before adding
//   carry_in  carry into bit 0
//   sum       LIMB-bit sum
//   carry_out carry out of bit LIMB-1
// -----------------------------------------------------------------------------
module mp_limb_adder #(
  parameter int LIMB = 64
) (
  input  logic [LIMB-1:0] a,
  input  logic [LIMB-1:0] b,
  input  logic            invert_b,
  input  logic            carry_in,
  output logic [LIMB-1:0] sum,
  output logic            carry_out
);

  logic [LIMB:0] full_sum;

  assign full_sum  = {1'b0, a} + {1'b0, b ^ {LIMB{invert_b}}} + {{LIMB{1'b0}}, carry_in};
  assign sum       = full_sum[LIMB-1:0];
  assign carry_out = full_sum[LIMB];

endmodule

// File: rtl/mp_addsub.sv
// -----------------------------------------------------------------------------
// mp_addsub
// Multi-precision adder/subtractor processing one LIMB-bit slice per clock.
// Supports add, subtract, conditional (modular) subtract and a one-cycle
// logical right shift of the result register.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      request, accepted only when idle
//   op         00 add, 01 sub, 10 modsub, 11 treated as add
//   in_a, in_b WIDTH-bit operands captured with start
//   shift      when idle: out_result <= out_result >> 1
//   out_result WIDTH+1-bit result
//   done       one-cycle pulse when out_result is valid
//   busy       high while an operation is in flight
//   borrow     A < B for sub/modsub, 0 for add
// -----------------------------------------------------------------------------
module mp_addsub
  import mp_arith_pkg::*;
#(
  parameter int WIDTH = 514,
  parameter int LIMB  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             shift,
  output logic [WIDTH:0]   out_result,
  output logic             done,
  output logic             busy,
  output logic             borrow
);

  localparam int NLIMB = nlimb(WIDTH, LIMB);
  localparam int PW    = NLIMB * LIMB;
  localparam int KW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  state_e          state;
  state_e          next_state;
  op_e             op_reg;
  op_e             op_dec;
  logic [PW-1:0]   a_reg;
  logic [PW-1:0]   b_reg;
  logic [PW-1:0]   res_sh;
  logic [PW-1:0]   res_next;
  logic [PW:0]     ext_full;
  logic [LIMB-1:0] limb_sum;
  logic [KW-1:0]   k;
  logic            res_top;
  logic            carry;
  logic            cout;
  logic            top_next;
  logic            op_is_sub;
  logic            last_limb;
  logic            accept;
  logic            do_shift;

  // Reserved encoding 11 falls through to add.
  always_comb begin
    op_dec = OP_ADD;
    case (op)
      2'b01:   op_dec = OP_SUB;
      2'b10:   op_dec = OP_MODSUB;
      default: op_dec = OP_ADD;
    endcase
  end

  assign op_is_sub = (op_reg != OP_ADD);
  assign last_limb = (k == KW'(NLIMB - 1));

  mp_limb_adder #(
    .LIMB(LIMB)
  ) u_limb_adder (
    .a        (a_reg[LIMB-1:0]),
    .b        (b_reg[LIMB-1:0]),
    .invert_b (op_is_sub),
    .carry_in (carry),
    .sum      (limb_sum),
    .carry_out(cout)
  );

  // New limbs enter at the top of the result register, so after NLIMB cycles
  // limb 0 has arrived at the bottom. ext_full extends the padded result by
  // one bit holding bit PW of the true (A +/- B); for sub that bit is the
  // inverted carry. Result bit WIDTH is then read from ext_full regardless of
  // whether WIDTH fills the padded width exactly.
  assign res_next = PW'({limb_sum, res_sh} >> LIMB);
  assign ext_full = {(op_is_sub ? ~cout : cout), res_next};
  assign top_next = 1'(ext_full >> WIDTH);

  assign out_result = {res_top, res_sh[WIDTH-1:0]};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. busy is still high in the cycle done pulses, so a start
  // or shift presented during that cycle is ignored along with those seen
  // during RUN/SEL/DONE.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    do_shift   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!busy) begin
          if (start) begin
            accept     = 1'b1;
            next_state = ST_RUN;
          end else if (shift) begin
            do_shift = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (last_limb) begin
          next_state = (op_reg == OP_MODSUB) ? ST_SEL : ST_DONE;
        end
      end
      ST_SEL:  next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath. A is rotated rather than shifted so that after the last limb it
  // is back in place for the modsub correction; B only needs to be consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_sh  <= '0;
      res_top <= 1'b0;
      carry   <= 1'b0;
      k       <= '0;
      op_reg  <= OP_ADD;
      borrow  <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= (state == ST_DONE);
      busy <= (state != ST_IDLE);
      if (accept) begin
        a_reg  <= PW'(in_a);
        b_reg  <= PW'(in_b);
        op_reg <= op_dec;
        carry  <= (op_dec != OP_ADD);
        k      <= '0;
      end else if (do_shift) begin
        res_sh  <= PW'(out_result >> 1);
        res_top <= 1'b0;
      end else if (state == ST_RUN) begin
        res_sh <= res_next;
        a_reg  <= PW'({a_reg, a_reg} >> LIMB);
        b_reg  <= b_reg >> LIMB;
        carry  <= cout;
        k      <= k + KW'(1);
        if (last_limb) begin
          res_top <= top_next;
          borrow  <= op_is_sub & ~cout;
        end
      end else if (state == ST_SEL) begin
        if (borrow) begin
          res_sh <= a_reg;
        end
        res_top <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mp_addsub.sv
// -----------------------------------------------------------------------------
// tb_mp_addsub
// Self-checking bench for mp_addsub: one instance at default parameters and
// one at WIDTH=130, LIMB=32. Expected results come from plain wide arithmetic.
// -----------------------------------------------------------------------------
module tb_mp_addsub;

  localparam int W1 = 514;
  localparam int L1 = 64;
  localparam int W2 = 130;
  localparam int L2 = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start1, shift1, done1, busy1, borrow1;
  logic [1:0]    op1;
  logic [W1-1:0] a1, b1;
  logic [W1:0]   res1;
  logic          start2, shift2, done2, busy2, borrow2;
  logic [1:0]    op2;
  logic [W2-1:0] a2, b2;
  logic [W2:0]   res2;

  int compare_count  = 0;
  int mismatch_count = 0;

  mp_addsub #(.WIDTH(W1), .LIMB(L1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op1), .in_a(a1), .in_b(b1),
    .shift(shift1), .out_result(res1), .done(done1), .busy(busy1), .borrow(borrow1)
  );

  mp_addsub #(.WIDTH(W2), .LIMB(L2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .op(op2), .in_a(a2), .in_b(b2),
    .shift(shift2), .out_result(res2), .done(done2), .busy(busy2), .borrow(borrow2)
  );

  // Counts every comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [515:0] observed,
                             input logic [515:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: the arithmetic result truncated to w+1 bits.
  function automatic logic [515:0] model_result(input logic [1:0] op_v,
                                                input logic [515:0] a_v,
                                                input logic [515:0] b_v,
                                                input int w);
    logic [515:0] r;
    logic [515:0] m;
    m = (516'd1 << (w + 1)) - 516'd1;
    if (op_v == 2'b01)      r = a_v - b_v;
    else if (op_v == 2'b10) r = (a_v < b_v) ? a_v : a_v - b_v;
    else                    r = a_v + b_v;
    return r & m;
  endfunction

  function automatic logic model_borrow(input logic [1:0] op_v,
                                        input logic [515:0] a_v,
                                        input logic [515:0] b_v);
    return ((op_v == 2'b01) || (op_v == 2'b10)) && (a_v < b_v);
  endfunction

  function automatic logic [515:0] rand_vec(input int w);
    logic [515:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    r[515:512] = 4'($urandom);
    return r & ((516'd1 << w) - 516'd1);
  endfunction

  // Runs one operation on the selected instance and checks latency, result,
  // borrow, busy timing and that done is a single pulse.
  task automatic applyStimulus(input bit use2, input logic [1:0] op_v,
                               input logic [515:0] a_v, input logic [515:0] b_v,
                               input string tag);
    int w, lim, exp_lat, lat;
    bit got;
    logic [515:0] obs;
    w       = use2 ? W2 : W1;
    lim     = use2 ? L2 : L1;
    exp_lat = (w + lim - 1) / lim + 1 + ((op_v == 2'b10) ? 1 : 0);
    @(negedge clk);
    if (use2) begin
      start2 = 1'b1; op2 = op_v; a2 = a_v[W2-1:0]; b2 = b_v[W2-1:0];
    end else begin
      start1 = 1'b1; op1 = op_v; a1 = a_v[W1-1:0]; b1 = b_v[W1-1:0];
    end
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
    checkOutput({tag, "_busy_e0"}, 516'(use2 ? busy2 : busy1), 516'd0);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) checkOutput({tag, "_busy_e1"}, 516'(use2 ? busy2 : busy1), 516'd1);
      if (use2 ? done2 : done1) got = 1'b1;
    end
    checkOutput({tag, "_latency"}, 516'(lat), 516'(exp_lat));
    obs = use2 ? 516'(res2) : 516'(res1);
    checkOutput({tag, "_result"}, obs, model_result(op_v, a_v, b_v, w));
    checkOutput({tag, "_borrow"}, 516'(use2 ? borrow2 : borrow1),
                516'(model_borrow(op_v, a_v, b_v)));
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_fall"}, 516'(use2 ? done2 : done1), 516'd0);
    checkOutput({tag, "_busy_fall"}, 516'(use2 ? busy2 : busy1), 516'd0);
  endtask

  // One-cycle shift pulse on the default instance.
  task automatic shiftAndCheck(input string tag);
    logic [515:0] expv;
    expv = 516'(res1) >> 1;
    @(negedge clk);
    shift1 = 1'b1;
    @(posedge clk);
    #1;
    shift1 = 1'b0;
    checkOutput(tag, 516'(res1), expv);
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [515:0] va, vb, expv, obs;
    logic [1:0]   rop;
    int           pulses;

    reset = 1'b1;
    start1 = 1'b0; shift1 = 1'b0; op1 = 2'b00; a1 = '0; b1 = '0;
    start2 = 1'b0; shift2 = 1'b0; op2 = 2'b00; a2 = '0; b2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_result", 516'(res1), 516'd0);
    checkOutput("rst_done", 516'(done1), 516'd0);
    checkOutput("rst_busy", 516'(busy1), 516'd0);
    checkOutput("rst_borrow", 516'(borrow1), 516'd0);
    checkOutput("rst_result2", 516'(res2), 516'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases from the default instance.
    applyStimulus(1'b0, 2'b00, 516'd1, 516'd1, "add_1p1");
    va = rand_vec(W1);
    vb = rand_vec(W1);
    applyStimulus(1'b0, 2'b00, va, vb, "add_rand");
    shiftAndCheck("shift_add_rand");
    applyStimulus(1'b0, 2'b00, (516'd1 << W1) - 516'd1, 516'd1, "add_carry_top");
    applyStimulus(1'b0, 2'b01, 516'd1, 516'd1, "sub_1m1");
    applyStimulus(1'b0, 2'b01, 516'd1, 516'd2, "sub_1m2");
    shiftAndCheck("shift_neg");
    applyStimulus(1'b0, 2'b10, 516'd7, 516'd5, "modsub_7_5");
    applyStimulus(1'b0, 2'b10, 516'd5, 516'd7, "modsub_5_7");

    // Random operations, including the reserved encoding.
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      va  = rand_vec(W1);
      vb  = rand_vec(W1);
      if (i == 2) vb = va;
      applyStimulus(1'b0, rop, va, vb, $sformatf("rand1_%0d", i));
    end

    // start held through RUN and a shift while busy must not disturb the sub.
    va   = rand_vec(W1);
    vb   = rand_vec(W1);
    expv = model_result(2'b01, va, vb, W1);
    @(negedge clk);
    start1 = 1'b1; op1 = 2'b01; a1 = va[W1-1:0]; b1 = vb[W1-1:0];
    @(posedge clk);
    #1;
    a1  = ~a1;
    op1 = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    shift1 = 1'b1;
    @(posedge clk);
    #1;
    shift1 = 1'b0;
    start1 = 1'b0;
    pulses = 0;
    obs    = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        pulses++;
        obs = 516'(res1);
      end
    end
    checkOutput("held_pulses", 516'(pulses), 516'd1);
    checkOutput("held_result", obs, expv);
    checkOutput("held_borrow", 516'(borrow1), 516'(model_borrow(2'b01, va, vb)));

    // Reset in the middle of an add, after a sub left borrow set.
    applyStimulus(1'b0, 2'b01, 516'd1, 516'd2, "pre_rst_sub");
    @(negedge clk);
    start1 = 1'b1; op1 = 2'b00; a1 = rand_vec(W1); b1 = rand_vec(W1);
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_result", 516'(res1), 516'd0);
    checkOutput("midrst_done", 516'(done1), 516'd0);
    checkOutput("midrst_busy", 516'(busy1), 516'd0);
    checkOutput("midrst_borrow", 516'(borrow1), 516'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 2'b00, 516'd1, 516'd1, "add_after_rst");

    // Narrow instance: random add/sub/modsub.
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 2));
      va  = rand_vec(W2);
      vb  = rand_vec(W2);
      applyStimulus(1'b1, rop, va, vb, $sformatf("rand2_%0d", i));
    end
    applyStimulus(1'b1, 2'b01, 516'd3, 516'd9, "w2_sub_neg");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
